prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
//   state_t       : loader FSM state encoding (3 bits)
//   SYNC_DEFAULT  : default frame header byte
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_BASE  = 3'd2,
        ST_INSTR = 3'd3,
        ST_ARG   = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream and writes (opcode, argument)
// pairs into program memory while holding the CPU in reset.
// Frame: SYNC, COUNT, BASE, COUNT x (INSTR, ARG), CSUM.
// CSUM is the modulo-2^WIDTH sum of every byte after SYNC.
// Ports:
//   clk, rst           : clock, async active-low reset
//   in_data/in_valid   : byte stream in; in_ready is the accept handshake
//   wr_en/wr_addr/
//   wr_instr/wr_arg    : program-memory write port (one strobe per pair)
//   cpu_hold           : keeps CPU PC/flags in reset during a load
//   done               : one-cycle pulse after a frame with a good checksum
//   err                : sticky checksum error, cleared by the next SYNC
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(SYNC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_instr,
    output logic [WIDTH-1:0] wr_arg,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    state_t           state, state_nxt;
    logic             accept;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] opcode;
    logic [WIDTH-1:0] sum;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and handshake
    always_comb begin
        state_nxt = state;
        in_ready  = (state != ST_DONE);
        accept    = in_valid && in_ready;
        case (state)
            ST_IDLE:  if (accept && in_data == SYNC) state_nxt = ST_COUNT;
            ST_COUNT: if (accept) state_nxt = ST_BASE;
            // cnt already holds COUNT here; an empty frame skips the pairs
            ST_BASE:  if (accept) state_nxt = (cnt == '0) ? ST_CSUM : ST_INSTR;
            ST_INSTR: if (accept) state_nxt = ST_ARG;
            ST_ARG:   if (accept) state_nxt = (cnt == WIDTH'(1)) ? ST_CSUM : ST_INSTR;
            ST_CSUM:  if (accept) state_nxt = (in_data == sum) ? ST_DONE : ST_IDLE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: counter, address, opcode, running sum and registered outputs.
    // wr_en and done default low every cycle so they are single-cycle strobes;
    // wr_addr/wr_instr/wr_arg only load on a write and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            addr     <= '0;
            opcode   <= '0;
            sum      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_instr <= '0;
            wr_arg   <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (in_data == SYNC) begin
                            err      <= 1'b0;
                            sum      <= '0;
                            cpu_hold <= 1'b1;
                        end
                    end
                    ST_COUNT: begin
                        cnt <= in_data;
                        sum <= sum + in_data;
                    end
                    ST_BASE: begin
                        addr <= in_data;
                        sum  <= sum + in_data;
                    end
                    ST_INSTR: begin
                        opcode <= in_data;
                        sum    <= sum + in_data;
                    end
                    ST_ARG: begin
                        wr_en    <= 1'b1;
                        wr_addr  <= addr;
                        wr_instr <= opcode;
                        wr_arg   <= in_data;
                        addr     <= addr + WIDTH'(1);
                        cnt      <= cnt - WIDTH'(1);
                        sum      <= sum + in_data;
                    end
                    ST_CSUM: begin
                        // Writes already issued stay in memory on a bad checksum
                        cpu_hold <= 1'b0;
                        if (in_data == sum) done <= 1'b1;
                        else                err  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames
// with random in_valid gaps, checked against a frame-level reference model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr, wr_instr, wr_arg;
    logic       cpu_hold, done, err;

    int total = 0;
    int bad   = 0;

    prog_loader #(.WIDTH(8), .SYNC(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_instr(wr_instr), .wr_arg(wr_arg), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    logic [23:0] got[$];
    int          got_cyc[$];
    int          done_cnt   = 0;
    int          ready_viol = 0;
    int          cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                got.push_back({wr_addr, wr_instr, wr_arg});
                got_cyc.push_back(cyc);
            end
            if (done) done_cnt = done_cnt + 1;
            // in_ready may only be low during the single DONE cycle
            if (!in_ready && !done) ready_viol = ready_viol + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  pi[0:255];
    logic [7:0]  pa[0:255];
    logic [23:0] exp_w[$];

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] b, input bit rnd);
        bit acc;
        int t;
        if (rnd) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 50) begin
            acc = in_ready;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout byte=%02h not accepted within 50 cycles", b);
        end
    endtask

    // Sends a full frame of n pairs from pi/pa; bad_cs corrupts the checksum.
    task automatic send_frame(input int n, input logic [7:0] base,
                              input bit bad_cs, input bit rnd, input string nm);
        logic [7:0] cs;
        got.delete();
        got_cyc.delete();
        exp_w.delete();
        done_cnt = 0;
        cs = 8'(n) + base;
        for (int i = 0; i < n; i++) begin
            cs = cs + pi[i] + pa[i];
            exp_w.push_back({8'(base + 8'(i)), pi[i], pa[i]});
        end
        if (bad_cs) cs = cs + 8'h01;
        send(8'hA5, rnd);
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL %s_hold_after_sync got=%b want=1", nm, cpu_hold);
        end
        send(8'(n), rnd);
        send(base, rnd);
        for (int i = 0; i < n; i++) begin
            send(pi[i], rnd);
            send(pa[i], rnd);
        end
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL %s_hold_before_csum got=%b want=1", nm, cpu_hold);
        end
        send(cs, rnd);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string nm, input bit exp_err);
        total++;
        if (got.size() !== exp_w.size()) begin
            bad++;
            $display("FAIL %s_write_count got=%0d want=%0d", nm, got.size(), exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                total++;
                if (got[i] !== exp_w[i]) begin
                    bad++;
                    $display("FAIL %s_write%0d got=%06h want=%06h", nm, i, got[i], exp_w[i]);
                end
            end
        end
        total++;
        if (done_cnt !== (exp_err ? 0 : 1)) begin
            bad++;
            $display("FAIL %s_done_pulses got=%0d want=%0d", nm, done_cnt, exp_err ? 0 : 1);
        end
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL %s_err got=%b want=%b", nm, err, exp_err);
        end
        total++;
        if (cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL %s_hold_after got=%b want=0", nm, cpu_hold);
        end
        total++;
        if (ready_viol !== 0) begin
            bad++;
            $display("FAIL %s_in_ready low outside DONE count=%0d want=0", nm, ready_viol);
        end
        ready_viol = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({wr_en, done, err, cpu_hold, wr_addr, wr_instr, wr_arg, in_ready} !== {4'b0, 24'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got=%b/%b/%b/%b %h %h %h rdy=%b want all 0, rdy=1",
                     wr_en, done, err, cpu_hold, wr_addr, wr_instr, wr_arg, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pi[0] = 8'h11; pa[0] = 8'h22;
        pi[1] = 8'h33; pa[1] = 8'h44;
        send_frame(2, 8'h10, 1'b0, 1'b0, "basic");
        check_frame("basic", 1'b0);
        total++;
        if (got.size() == 2 && (got[0] !== 24'h101122 || got[1] !== 24'h113344)) begin
            bad++;
            $display("FAIL basic_literal got=%06h,%06h want=101122,113344", got[0], got[1]);
        end
        total++;
        if (got_cyc.size() != 2 || got_cyc[1] - got_cyc[0] != 2) begin
            bad++;
            $display("FAIL basic_write_spacing got=%0d want=2",
                     got_cyc.size() == 2 ? got_cyc[1] - got_cyc[0] : -1);
        end
    endtask

    task automatic test_bad_csum();
        pi[0] = 8'h11; pa[0] = 8'h22;
        pi[1] = 8'h33; pa[1] = 8'h44;
        send_frame(2, 8'h10, 1'b1, 1'b0, "badcs");
        check_frame("badcs", 1'b1);
        // idle garbage must not clear the sticky flag
        send(8'h00, 1'b0);
        send(8'h5A, 1'b0);
        repeat (2) @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL badcs_sticky got=%b want=1", err);
        end
        send_frame(2, 8'h10, 1'b0, 1'b0, "badcs_recover");
        check_frame("badcs_recover", 1'b0);
    endtask

    task automatic test_wrap();
        pi[0] = 8'h01; pa[0] = 8'h02;
        pi[1] = 8'h03; pa[1] = 8'h04;
        send_frame(2, 8'hFF, 1'b0, 1'b0, "wrap");
        check_frame("wrap", 1'b0);
        total++;
        if (got.size() == 2 && (got[0][23:16] !== 8'hFF || got[1][23:16] !== 8'h00)) begin
            bad++;
            $display("FAIL wrap_addr got=%02h,%02h want=ff,00", got[0][23:16], got[1][23:16]);
        end
    endtask

    task automatic test_zero_count();
        send_frame(0, 8'h20, 1'b0, 1'b0, "zero");
        check_frame("zero", 1'b0);
    endtask

    task automatic test_sync_in_data();
        // header byte inside the frame is plain data
        pi[0] = 8'hA5; pa[0] = 8'hA5;
        pi[1] = 8'h7E; pa[1] = 8'hA5;
        send_frame(2, 8'hA5, 1'b0, 1'b0, "syncdata");
        check_frame("syncdata", 1'b0);
    endtask

    task automatic test_reset_mid();
        pi[0] = 8'hDE; pa[0] = 8'hAD;
        send_frame(1, 8'h40, 1'b1, 1'b0, "premid");
        check_frame("premid", 1'b1);
        send(8'h00, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_hold_before got=%b want=1", cpu_hold);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({wr_en, done, err, cpu_hold, wr_addr, wr_instr, wr_arg} !== 28'h0) begin
            bad++;
            $display("FAIL rstmid_async got=%b/%b/%b/%b %h %h %h want all 0",
                     wr_en, done, err, cpu_hold, wr_addr, wr_instr, wr_arg);
        end
        @(negedge clk);
        rst = 1'b1;
        pi[0] = 8'h11; pa[0] = 8'h22;
        pi[1] = 8'h33; pa[1] = 8'h44;
        send_frame(2, 8'h10, 1'b0, 1'b0, "postrst");
        check_frame("postrst", 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n;
            bit b;
            n = $urandom_range(0, 6);
            b = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) begin
                pi[i] = 8'($urandom);
                pa[i] = 8'($urandom);
            end
            send_frame(n, 8'($urandom), b, 1'b1, "rand");
            check_frame("rand", b);
        end
        // the reference frame again, with random gaps
        pi[0] = 8'h11; pa[0] = 8'h22;
        pi[1] = 8'h33; pa[1] = 8'h44;
        send_frame(2, 8'h10, 1'b0, 1'b1, "gapped");
        check_frame("gapped", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_wrap();
        test_zero_count();
        test_sync_in_data();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
